// File: rtl/pito_loader_if.sv
// Command, stream, memory-write and core-control bundle between a host and pito_loader.
// Latency: none; this is wiring only.
// Backpressure: the loader (slave) drives cmd_ready and s_ready; the host (master) must hold offers until accepted.
interface pito_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  // load command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_target;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  // program word stream
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  // instruction / data memory write ports
  logic              imem_w_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              dmem_w_en;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_data;
  // core control and status
  logic              start;
  logic              stop;
  logic              core_rst_n;
  logic              core_program;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_target, cmd_base, cmd_len, s_valid, s_data, start, stop,
    input  cmd_ready, s_ready, imem_w_en, imem_addr, imem_data,
           dmem_w_en, dmem_addr, dmem_data, core_rst_n, core_program, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_base, cmd_len, s_valid, s_data, start, stop,
    output cmd_ready, s_ready, imem_w_en, imem_addr, imem_data,
           dmem_w_en, dmem_addr, dmem_data, core_rst_n, core_program, busy, done, err
  );
endinterface

// File: rtl/pito_loader.sv
// Loads a word stream into instruction or data memory, then sequences the core out of reset.
// Latency: each accepted stream word appears on the memory write port one cycle later; done rides with the last write.
// Backpressure: cmd_ready only in IDLE, s_ready only in LOAD; no internal buffering, so words are written as they arrive.
module pito_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RST_HOLD = 4
) (
  input logic         rv32_io_clk,
  input logic         rv32_io_rst,
  pito_loader_if.slave bus
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_W+1:0] DEPTH_W   = (ADDR_W+2)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              iw_en_q, iw_en_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic              dw_en_q, dw_en_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;

  logic [ADDR_W+1:0] cmd_end;
  logic              cmd_bad;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   cnt_inc;

  // Command legality and the address of the word currently being accepted.
  always_comb begin
    cmd_end = {2'b00, bus.cmd_base} + {1'b0, bus.cmd_len};
    cmd_bad = (bus.cmd_len == '0) || (cmd_end > DEPTH_W);
    wr_addr = base_q + cnt_q[ADDR_W-1:0];
    cnt_inc = cnt_q + (ADDR_W+1)'(1);
  end

  // Next-state and registered-output logic; write strobes default low so they only follow a handshake.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
    done_d  = 1'b0;
    iw_en_d = 1'b0;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    dw_en_d = 1'b0;
    daddr_d = daddr_q;
    ddata_d = ddata_q;

    case (state_q)
      IDLE: begin
        // A command beats a simultaneous start.
        if (bus.cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            tgt_d   = bus.cmd_target;
            base_d  = bus.cmd_base;
            len_d   = bus.cmd_len;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end else if (bus.start) begin
          hold_d  = '0;
          state_d = RELEASE;
        end
      end

      LOAD: begin
        if (bus.s_valid) begin
          if (tgt_q) begin
            dw_en_d = 1'b1;
            daddr_d = wr_addr;
            ddata_d = bus.s_data;
          end else begin
            iw_en_d = 1'b1;
            iaddr_d = wr_addr;
            idata_d = bus.s_data;
          end
          cnt_d = cnt_inc;
          // Leaving LOAD on the last word keeps the address from running past base+len-1.
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RELEASE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset also discards any partial load.
  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      iw_en_q <= 1'b0;
      iaddr_q <= '0;
      idata_q <= '0;
      dw_en_q <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      done_q  <= done_d;
      iw_en_q <= iw_en_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      dw_en_q <= dw_en_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  // Handshake readiness and core control decode straight from the state register.
  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.s_ready      = (state_q == LOAD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.core_program = (state_q == LOAD);
  assign bus.core_rst_n   = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.imem_w_en    = iw_en_q;
  assign bus.imem_addr    = iaddr_q;
  assign bus.imem_data    = idata_q;
  assign bus.dmem_w_en    = dw_en_q;
  assign bus.dmem_addr    = daddr_q;
  assign bus.dmem_data    = ddata_q;

endmodule

// File: tb/tb_pito_loader.sv
// Directed bench for pito_loader with a transaction-level reference model checked every cycle.
// Latency: model predicts writes one cycle after each accepted stream word.
// Backpressure: stimulus is timed directly against the model's notion of when the loader is ready.
module tb_pito_loader;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int DEPTH    = 1024;
  localparam int RST_HOLD = 4;

  logic clk;
  logic rst;

  pito_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pito_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD)
  ) dut (
    .rv32_io_clk(clk),
    .rv32_io_rst(rst),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_REL, M_RUN} mphase_t;
  mphase_t           m_st;
  logic              m_tgt;
  int                m_next, m_left, m_hold;
  logic              e_iw, e_dw, e_done, e_err;
  logic [ADDR_W-1:0] e_iaddr, e_daddr;
  logic [DATA_W-1:0] e_idata, e_ddata;

  // The model sees the same inputs the DUT samples at the edge and predicts the next cycle's outputs.
  always @(posedge clk) begin
    e_iw   = 1'b0;
    e_dw   = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_tgt = 1'b0; m_next = 0; m_left = 0; m_hold = 0;
      e_err = 1'b0; e_iaddr = '0; e_idata = '0; e_daddr = '0; e_ddata = '0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_len == 0 || int'(bus.cmd_base) + int'(bus.cmd_len) > DEPTH) begin
              e_err = 1'b1;
            end else begin
              e_err  = 1'b0;
              m_tgt  = bus.cmd_target;
              m_next = int'(bus.cmd_base);
              m_left = int'(bus.cmd_len);
              m_st   = M_LOAD;
            end
          end else if (bus.start) begin
            m_hold = RST_HOLD;
            m_st   = M_REL;
          end
        end
        M_LOAD: begin
          if (bus.s_valid) begin
            if (m_tgt) begin
              e_dw = 1'b1; e_daddr = ADDR_W'(m_next); e_ddata = bus.s_data;
            end else begin
              e_iw = 1'b1; e_iaddr = ADDR_W'(m_next); e_idata = bus.s_data;
            end
            m_next++;
            m_left--;
            if (m_left == 0) begin
              e_done = 1'b1;
              m_st   = M_IDLE;
            end
          end
        end
        M_REL: begin
          if (bus.stop) m_st = M_IDLE;
          else begin
            m_hold--;
            if (m_hold == 0) m_st = M_RUN;
          end
        end
        M_RUN: if (bus.stop) m_st = M_IDLE;
        default: m_st = M_IDLE;
      endcase
    end
  end

  typedef struct {
    logic              tgt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
  } wr_t;
  wr_t wlog[$];

  // Per-cycle comparison against the model, plus a log of observed writes for the directed checks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("cmd_ready",    bus.cmd_ready,    m_st == M_IDLE);
      chk("s_ready",      bus.s_ready,      m_st == M_LOAD);
      chk("busy",         bus.busy,         m_st != M_IDLE);
      chk("core_program", bus.core_program, m_st == M_LOAD);
      chk("core_rst_n",   bus.core_rst_n,   m_st == M_RUN);
      chk("done",         bus.done,         e_done);
      chk("err",          bus.err,          e_err);
      chk("imem_w_en",    bus.imem_w_en,    e_iw);
      chk("dmem_w_en",    bus.dmem_w_en,    e_dw);
      chk("imem_addr",    bus.imem_addr,    e_iaddr);
      chk("imem_data",    bus.imem_data,    e_idata);
      chk("dmem_addr",    bus.dmem_addr,    e_daddr);
      chk("dmem_data",    bus.dmem_data,    e_ddata);
      if (bus.imem_w_en === 1'b1) wlog.push_back('{1'b0, bus.imem_addr, bus.imem_data, bus.done});
      if (bus.dmem_w_en === 1'b1) wlog.push_back('{1'b1, bus.dmem_addr, bus.dmem_data, bus.done});
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send_cmd(input logic tgt, input int base, input int len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    bus.cmd_base   = ADDR_W'(base);
    bus.cmd_len    = (ADDR_W+1)'(len);
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic stream(input int n, input int gap, input logic [DATA_W-1:0] first,
                        input logic [DATA_W-1:0] step);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = first + step * DATA_W'(i);
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  logic [DATA_W-1:0] t1_dat [4] = '{32'h13, 32'h93, 32'h113, 32'h193};
  int rel_cycles;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_target = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  bus.cmd_ready,  1'b1);
    chk("rst_core_rst_n", bus.core_rst_n, 1'b0);
    chk("rst_imem_addr",  bus.imem_addr,  '0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back instruction load of four words from address 0.
    wlog.delete();
    send_cmd(1'b0, 0, 4);
    stream(4, 0, 32'h13, 32'h80);
    repeat (2) @(negedge clk);
    chk("t1_nwr", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) begin
      chk("t1_tgt",  wlog[i].tgt,  1'b0);
      chk("t1_addr", wlog[i].addr, ADDR_W'(i));
      chk("t1_data", wlog[i].data, t1_dat[i]);
      chk("t1_done", wlog[i].done, i == 3);
    end
    chk("t1_idle", bus.cmd_ready, 1'b1);

    // Data load at the top of memory with a bubbly stream.
    wlog.delete();
    send_cmd(1'b1, 'h3FE, 2);
    stream(2, 1, 32'hA5A5_0000, 32'h1);
    repeat (2) @(negedge clk);
    chk("t2_nwr", wlog.size(), 2);
    for (int i = 0; i < wlog.size() && i < 2; i++) begin
      chk("t2_tgt",  wlog[i].tgt,  1'b1);
      chk("t2_addr", wlog[i].addr, ADDR_W'('h3FE + i));
    end

    // Out-of-range and zero-length commands flag err; a good command clears it.
    wlog.delete();
    send_cmd(1'b0, 'h3FF, 2);
    @(negedge clk);
    chk("t3_err_range", bus.err, 1'b1);
    chk("t3_ready",     bus.cmd_ready, 1'b1);
    send_cmd(1'b1, 5, 0);
    @(negedge clk);
    chk("t3_err_zero",  bus.err, 1'b1);
    chk("t3_nwr",       wlog.size(), 0);
    send_cmd(1'b1, 5, 1);
    chk("t3_err_clr",   bus.err, 1'b0);
    stream(1, 0, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    chk("t3_nwr_good",  wlog.size(), 1);

    // Release sequence: core held in reset for RST_HOLD cycles, then run; start in RUN ignored; stop.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rel_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.core_rst_n === 1'b1) break;
      rel_cycles++;
      @(negedge clk);
    end
    chk("t4_hold", rel_cycles, 4);
    chk("t4_run",  bus.core_rst_n, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("t4_stop_rst_n", bus.core_rst_n, 1'b0);
    chk("t4_stop_ready", bus.cmd_ready,  1'b1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;

    // start and cmd_valid together: the command wins; stop during LOAD is ignored.
    bus.start = 1'b1;
    send_cmd(1'b0, 8, 1);
    bus.start = 1'b0;
    chk("t5_program", bus.core_program, 1'b1);
    chk("t5_rst_n",   bus.core_rst_n,   1'b0);
    bus.stop = 1'b1;
    stream(1, 0, 32'h0000_0777, 32'h0);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_n_after", bus.core_rst_n, 1'b0);

    // Reset after two of eight words, then a fresh load from address 0.
    send_cmd(1'b0, 'h10, 8);
    stream(2, 0, 32'h1000, 32'h4);
    rst = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    chk("t6_ready",   bus.cmd_ready,    1'b1);
    chk("t6_busy",    bus.busy,         1'b0);
    chk("t6_w_en",    bus.imem_w_en,    1'b0);
    chk("t6_addr",    bus.imem_addr,    '0);
    chk("t6_data",    bus.imem_data,    '0);
    chk("t6_program", bus.core_program, 1'b0);
    wlog.delete();
    send_cmd(1'b0, 0, 3);
    stream(3, 0, 32'h2000, 32'h1);
    repeat (2) @(negedge clk);
    chk("t6_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t6_last_addr", wlog[2].addr, ADDR_W'(2));
      chk("t6_last_data", wlog[2].data, 32'h2002);
      chk("t6_last_done", wlog[2].done, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
